llc_req_scheduler: RTL and testbench
====================================

// Module: llc_req_scheduler
// PURPOSE
//  Front-end sequencer for the LLC. Queues processor-side (L1) requests and bus-snoop requests, arbitrates
//  between them, and drives one op/addr pair per access into the LLC.
//  Re-issues a CPU access when the LLC raises hold after an eviction. Sits between the trace reader and LLC.
// PARAMETERS
//  FIFO_DEPTH    4   entries per request queue (power of 2, >=2)
//  MAX_RETRY     2   max re-issues of one CPU access before retry_err
//  STARVE_LIMIT  4   consecutive snoop grants before a forced CPU grant (LLC_SCHED_STARVE_GUARD_EN only)
// PORTS
//  clk         in   1   clock; all logic on posedge
//  rst_n       in   1   synchronous, active-low reset
//  cpu_valid   in   1   CPU request valid
//  cpu_op      in   4   trace op: 0 rd, 1 wr, 2 ifetch, 8 clear, 9 print
//  cpu_addr    in   32  CPU request address
//  cpu_ready   out  1   CPU FIFO not full; push when cpu_valid && cpu_ready
//  snp_valid   in   1   snoop request valid
//  snp_op      in   4   trace op: 3 snoop rd, 4 snoop wr, 5 snoop RWIM, 6 snoop inval
//  snp_addr    in   32  snoop request address
//  snp_ready   out  1   snoop FIFO not full
//  llc_op      out  32  op to LLC (integer); OP_NOP (15) when idle
//  llc_addr    out  32  address to LLC
//  llc_hold    in   32  LLC hold (integer); nonzero = evicted, re-access needed
//  busy        out  1   FSM not IDLE or either FIFO non-empty
//  bad_op      out  1   1-cycle pulse: dequeued op is illegal for its queue; entry dropped
//  retry_err   out  1   sticky; CPU access exceeded MAX_RETRY; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FIFOs emptied, FSM=IDLE, retry counter 0; llc_op=OP_NOP, llc_addr=0, bad_op=0,
//   retry_err=0, busy=0. Ready outputs are 1 after reset. Reset mid-access abandons it; no re-issue.
//  FIFOs: ready = !full; no bypass (push into a full FIFO is not accepted even if a pop occurs same cycle).
//   Ops are not checked on push.
//  FSM states: IDLE, ISSUE, CHECK.
//   IDLE: if any FIFO non-empty, pick a winner, pop it, register op/addr onto llc_op/llc_addr -> ISSUE.
//    Else llc_op=OP_NOP.
//   ISSUE: op is on the LLC input for exactly one posedge; next cycle llc_op=OP_NOP -> CHECK.
//   CHECK: LLC outputs from the ISSUE edge are now stable; sample llc_hold.
//    - CPU op 0/1/2 and llc_hold!=0: if retry_cnt<MAX_RETRY, retry_cnt++ and re-drive same op/addr -> ISSUE.
//      Else set retry_err, retry_cnt=0 -> IDLE.
//    - Otherwise retry_cnt=0 -> IDLE. Snoop ops and ops 8/9 are never retried.
//  Latency: empty scheduler to llc_op valid = 1 cycle after push. Each access occupies 2 cycles
//   (ISSUE+CHECK), +2 per retry. Throughput is therefore 1 access per 2 cycles.
//  Arbitration in IDLE: snoop wins whenever the snoop FIFO is non-empty (bus response must not wait).
//   Both empty -> stay IDLE.
//  Illegal op (CPU queue op not in {0,1,2,8,9}; snoop queue op not in {3,4,5,6}):
//   entry popped, bad_op=1 for one cycle, nothing driven, stay IDLE.
//  Order preserved within each queue; no reordering across an in-flight retry.
//  Pushes are accepted in any state, including ISSUE/CHECK, subject to full.
// CONFIGURATION
//  LLC_SCHED_STARVE_GUARD_EN defined:
//   - Counter starve_cnt increments on each snoop grant while the CPU FIFO is non-empty.
//   - Counter resets on any CPU grant or when the CPU FIFO is empty.
//   - When starve_cnt==STARVE_LIMIT, the next IDLE grant goes to the CPU head regardless of snoops.
//  Undefined: strict snoop priority; starve_cnt absent.
// STRUCTURE
//  LLC_defs additions: typedef enum llc_op_e {OP_RD=0, OP_WR=1, OP_IFETCH=2, OP_SNP_RD=3, OP_SNP_WR=4,
//   OP_SNP_RWIM=5, OP_SNP_INV=6, OP_CLEAR=8, OP_PRINT=9, OP_NOP=15};
//   typedef struct packed {logic [3:0] op; logic [31:0] addr;} llc_req_t; typedef enum sched_state_e.
//  Sub-module: llc_req_fifo (#DEPTH, llc_req_t payload; push/pop/full/empty), instantiated twice.
//  FSM, arbiter and retry logic live in the top.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles with cpu_valid=1 -> llc_op=15, cpu_ready=1, busy=0, no entry queued.
//  2 CPU op0 @0x0000_1000, llc_hold=0 -> llc_op=0 one cycle after push, then 15; busy falls after CHECK.
//  3 Simultaneous push cpu op1 @0xA0 and snp op3 @0xB0 -> llc_op=3 (0xB0) first, then 1 (0xA0) 2 cycles later.
//  4 CPU op0 @0x40, bench returns llc_hold=1 in first CHECK, 0 in second -> op0 @0x40 issued twice, retry_err=0.
//    With llc_hold stuck at 1 -> 3 issues total, then retry_err=1.
//  5 Push 5 CPU reqs back-to-back with FIFO_DEPTH=4 while stalled -> cpu_ready=0 after 4th; 5th held.
//    All 4 issued in order. Push cpu op7 -> bad_op pulse, no LLC issue.
//  6 Guard on, 6 snoops + 1 CPU queued -> 4 snoops, CPU, remaining 2 snoops. Guard off -> 6 snoops then CPU.

Source files
------------

// File: rtl/llc_req_scheduler_pkg.sv
// Shared types for the LLC request scheduler: trace op codes,
// queued request payload, FSM states and op legality helpers.
package llc_req_scheduler_pkg;

  typedef enum logic [3:0] {
    OP_RD       = 4'd0,
    OP_WR       = 4'd1,
    OP_IFETCH   = 4'd2,
    OP_SNP_RD   = 4'd3,
    OP_SNP_WR   = 4'd4,
    OP_SNP_RWIM = 4'd5,
    OP_SNP_INV  = 4'd6,
    OP_CLEAR    = 4'd8,
    OP_PRINT    = 4'd9,
    OP_NOP      = 4'd15
  } llc_op_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
  } llc_req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK
  } sched_state_e;

  function automatic logic cpu_op_ok(input logic [3:0] op);
    return op inside {OP_RD, OP_WR, OP_IFETCH,
                      OP_CLEAR, OP_PRINT};
  endfunction

  function automatic logic snp_op_ok(input logic [3:0] op);
    return op inside {OP_SNP_RD, OP_SNP_WR,
                      OP_SNP_RWIM, OP_SNP_INV};
  endfunction

  // Only real memory accesses can be evicted under us.
  function automatic logic cpu_op_retry(input logic [3:0] op);
    return op inside {OP_RD, OP_WR, OP_IFETCH};
  endfunction

endpackage

// File: rtl/llc_req_scheduler_fifo.sv
// llc_req_fifo: request queue, no bypass, sync active-low reset.
// Ports: clk, rst_n, i_push/i_data, i_pop, o_data (head), o_full, o_empty.
module llc_req_fifo
  import llc_req_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  llc_req_t i_data,
  input  logic     i_pop,
  output llc_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  llc_req_t    r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  // full is the pre-edge state, so a same-cycle pop never makes room.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/llc_req_scheduler.sv
// LLC front-end: queues CPU and snoop requests, arbitrates (snoop first),
// issues one op per access and re-issues CPU accesses the LLC evicted.
// Ports: clk, rst_n; cpu_valid/op/addr/ready; snp_valid/op/addr/ready;
// llc_op/llc_addr to LLC, llc_hold back; busy, bad_op, retry_err.
// Optional macro LLC_SCHED_STARVE_GUARD_EN: bound snoop run vs queued CPU.
module llc_req_scheduler
  import llc_req_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_RETRY    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_op,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  input  logic        snp_valid,
  input  logic [3:0]  snp_op,
  input  logic [31:0] snp_addr,
  output logic        snp_ready,
  output logic [31:0] llc_op,
  output logic [31:0] llc_addr,
  input  logic [31:0] llc_hold,
  output logic        busy,
  output logic        bad_op,
  output logic        retry_err
);

  localparam int CW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] MAX_R = CW'(MAX_RETRY);

  sched_state_e r_state;
  llc_req_t     r_req;
  logic         r_is_cpu;
  logic [CW-1:0] r_retry_cnt;
  logic [31:0]  r_llc_op;
  logic [31:0]  r_llc_addr;
  logic         r_bad_op;
  logic         r_retry_err;

  llc_req_t w_cpu_head, w_snp_head, w_sel;
  logic w_cpu_full, w_cpu_empty;
  logic w_snp_full, w_snp_empty;
  logic w_evicted, w_retry, w_over;
  logic w_can_grant, w_force_cpu;
  logic w_pick_snp, w_pick_cpu;
  logic w_pop_snp, w_pop_cpu, w_sel_ok;

  llc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_cpu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cpu_valid),
    .i_data  ({cpu_op, cpu_addr}),
    .i_pop   (w_pop_cpu),
    .o_data  (w_cpu_head),
    .o_full  (w_cpu_full),
    .o_empty (w_cpu_empty)
  );

  llc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_snp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (snp_valid),
    .i_data  ({snp_op, snp_addr}),
    .i_pop   (w_pop_snp),
    .o_data  (w_snp_head),
    .o_full  (w_snp_full),
    .o_empty (w_snp_empty)
  );

  assign w_evicted = (r_state == S_CHECK) && r_is_cpu &&
                     cpu_op_retry(r_req.op) && (llc_hold != '0);
  assign w_retry   = w_evicted && (r_retry_cnt < MAX_R);
  assign w_over    = w_evicted && !(r_retry_cnt < MAX_R);

  // A finished CHECK arbitrates like IDLE: back-to-back accesses.
  assign w_can_grant = (r_state == S_IDLE) ||
                       ((r_state == S_CHECK) && !w_retry);

`ifdef LLC_SCHED_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_L = SW'(STARVE_LIMIT);
  logic [SW-1:0] r_starve;

  assign w_force_cpu = (r_starve == STARVE_L);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_cpu_empty || w_pop_cpu) begin
      r_starve <= '0;
    end else if (w_pop_snp && !w_force_cpu) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force_cpu = 1'b0;
`endif

  assign w_pick_snp = !w_snp_empty && !(w_force_cpu && !w_cpu_empty);
  assign w_pick_cpu = !w_cpu_empty && !w_pick_snp;
  assign w_pop_snp  = w_can_grant && w_pick_snp;
  assign w_pop_cpu  = w_can_grant && w_pick_cpu;
  assign w_sel      = w_pick_snp ? w_snp_head : w_cpu_head;
  assign w_sel_ok   = w_pick_snp ? snp_op_ok(w_snp_head.op)
                                 : cpu_op_ok(w_cpu_head.op);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_is_cpu    <= 1'b0;
      r_retry_cnt <= '0;
      r_llc_op    <= 32'(OP_NOP);
      r_llc_addr  <= '0;
      r_bad_op    <= 1'b0;
      r_retry_err <= 1'b0;
    end else begin
      r_bad_op <= 1'b0;
      if (w_can_grant) begin
        r_retry_cnt <= '0;
        if (w_over) r_retry_err <= 1'b1;
        if ((w_pop_snp || w_pop_cpu) && w_sel_ok) begin
          r_req      <= w_sel;
          r_is_cpu   <= w_pop_cpu;
          r_llc_op   <= 32'(w_sel.op);
          r_llc_addr <= w_sel.addr;
          r_state    <= S_ISSUE;
        end else begin
          r_bad_op <= w_pop_snp || w_pop_cpu;
          r_state  <= S_IDLE;
        end
      end else if (r_state == S_ISSUE) begin
        r_llc_op <= 32'(OP_NOP);
        r_state  <= S_CHECK;
      end else if (w_retry) begin
        r_retry_cnt <= r_retry_cnt + 1'b1;
        r_llc_op    <= 32'(r_req.op);
        r_llc_addr  <= r_req.addr;
        r_state     <= S_ISSUE;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign cpu_ready = !w_cpu_full;
  assign snp_ready = !w_snp_full;
  assign llc_op    = r_llc_op;
  assign llc_addr  = r_llc_addr;
  assign bad_op    = r_bad_op;
  assign retry_err = r_retry_err;
  assign busy      = (r_state != S_IDLE) || !w_cpu_empty || !w_snp_empty;

endmodule

// File: tb/tb_llc_req_scheduler.sv
// Directed bench for llc_req_scheduler: reset, issue timing, arbitration,
// retry/retry_err, FIFO full, illegal op and snoop-vs-CPU ordering.
module tb_llc_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid;
  logic [3:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        snp_valid;
  logic [3:0]  snp_op;
  logic [31:0] snp_addr;
  logic        snp_ready;
  logic [31:0] llc_op;
  logic [31:0] llc_addr;
  logic [31:0] llc_hold = '0;
  logic        busy;
  logic        bad_op;
  logic        retry_err;

  int total = 0;
  int bad   = 0;

  logic [3:0]  log_op[$];
  logic [31:0] log_addr[$];
  int          hold_plan[$];

  always #5 clk = ~clk;

  llc_req_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_valid (cpu_valid),
    .cpu_op    (cpu_op),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .snp_valid (snp_valid),
    .snp_op    (snp_op),
    .snp_addr  (snp_addr),
    .snp_ready (snp_ready),
    .llc_op    (llc_op),
    .llc_addr  (llc_addr),
    .llc_hold  (llc_hold),
    .busy      (busy),
    .bad_op    (bad_op),
    .retry_err (retry_err)
  );

  // LLC model: log each issue and answer with the next planned hold value.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (llc_op != 32'd15) begin
        log_op.push_back(llc_op[3:0]);
        log_addr.push_back(llc_addr);
        llc_hold = (hold_plan.size() > 0) ? 32'(hold_plan.pop_front()) : 32'd0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx,
                         input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] o_op;
    logic [31:0] o_ad;
    o_op = (idx < log_op.size()) ? 32'(log_op[idx]) : 'x;
    o_ad = (idx < log_addr.size()) ? log_addr[idx] : 'x;
    chk({tag, "_op"}, o_op, 32'(op));
    chk({tag, "_addr"}, o_ad, addr);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_log();
    log_op.delete();
    log_addr.delete();
  endtask

  logic [3:0]  e_op[7];
  logic [31:0] e_ad[7];

  initial begin
    // 1: reset with a pushing CPU
    rst_n     = 1'b0;
    cpu_valid = 1'b1;
    cpu_op    = 4'd0;
    cpu_addr  = 32'h10;
    snp_valid = 1'b0;
    snp_op    = 4'd3;
    snp_addr  = '0;
    tick();
    tick();
    chk("rst_llc_op", llc_op, 32'd15);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("rst_snp_ready", 32'(snp_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    cpu_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_addr", llc_addr, 32'd0);
    chk("post_rst_bad_op", 32'(bad_op), 32'd0);
    chk("post_rst_retry_err", 32'(retry_err), 32'd0);

    // 2: single CPU read, no hold
    clear_log();
    cpu_valid = 1'b1;
    cpu_op    = 4'd0;
    cpu_addr  = 32'h0000_1000;
    tick();
    cpu_valid = 1'b0;
    chk("t2_pre_op", llc_op, 32'd15);
    chk("t2_busy_q", 32'(busy), 32'd1);
    tick();
    chk("t2_op", llc_op, 32'd0);
    chk("t2_addr", llc_addr, 32'h1000);
    tick();
    chk("t2_nop", llc_op, 32'd15);
    chk("t2_busy_chk", 32'(busy), 32'd1);
    tick();
    chk("t2_busy_done", 32'(busy), 32'd0);
    chk("t2_count", 32'(log_op.size()), 32'd1);

    // 3: simultaneous CPU and snoop push, snoop first
    clear_log();
    cpu_valid = 1'b1;
    cpu_op    = 4'd1;
    cpu_addr  = 32'hA0;
    snp_valid = 1'b1;
    snp_op    = 4'd3;
    snp_addr  = 32'hB0;
    tick();
    cpu_valid = 1'b0;
    snp_valid = 1'b0;
    tick();
    chk("t3_first_op", llc_op, 32'd3);
    chk("t3_first_addr", llc_addr, 32'hB0);
    tick();
    chk("t3_gap", llc_op, 32'd15);
    tick();
    chk("t3_second_op", llc_op, 32'd1);
    chk("t3_second_addr", llc_addr, 32'hA0);
    wait_idle("t3");

    // 4a: one eviction then success
    clear_log();
    hold_plan = '{1, 0};
    cpu_valid = 1'b1;
    cpu_op    = 4'd0;
    cpu_addr  = 32'h40;
    tick();
    cpu_valid = 1'b0;
    wait_idle("t4a");
    chk("t4a_count", 32'(log_op.size()), 32'd2);
    chk_log("t4a_0", 0, 4'd0, 32'h40);
    chk_log("t4a_1", 1, 4'd0, 32'h40);
    chk("t4a_retry_err", 32'(retry_err), 32'd0);

    // 4b: hold stuck -> 3 issues then retry_err
    clear_log();
    hold_plan = '{1, 1, 1};
    cpu_valid = 1'b1;
    tick();
    cpu_valid = 1'b0;
    wait_idle("t4b");
    chk("t4b_count", 32'(log_op.size()), 32'd3);
    chk_log("t4b_2", 2, 4'd0, 32'h40);
    chk("t4b_retry_err", 32'(retry_err), 32'd1);

    // 5: fill CPU FIFO while an evicted access stalls the scheduler
    clear_log();
    hold_plan = '{1, 1, 1};
    cpu_valid = 1'b1;
    cpu_op    = 4'd2;
    cpu_addr  = 32'h300;
    tick();
    cpu_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      cpu_valid = 1'b1;
      cpu_op    = 4'd1;
      cpu_addr  = 32'h400 + 32'(4 * i);
      tick();
    end
    chk("t5_full_ready", 32'(cpu_ready), 32'd0);
    cpu_addr = 32'h410;
    tick();
    chk("t5_held_ready", 32'(cpu_ready), 32'd0);
    tick();
    chk("t5_popped_ready", 32'(cpu_ready), 32'd1);
    chk("t5_head_op", llc_op, 32'd1);
    chk("t5_head_addr", llc_addr, 32'h400);
    cpu_valid = 1'b0;
    wait_idle("t5");
    chk("t5_count", 32'(log_op.size()), 32'd7);
    chk_log("t5_x", 2, 4'd2, 32'h300);
    chk_log("t5_r1", 4, 4'd1, 32'h404);
    chk_log("t5_r3", 6, 4'd1, 32'h40C);

    // 5b: illegal CPU op
    clear_log();
    cpu_valid = 1'b1;
    cpu_op    = 4'd7;
    cpu_addr  = 32'h500;
    tick();
    cpu_valid = 1'b0;
    tick();
    chk("t5b_bad_op", 32'(bad_op), 32'd1);
    chk("t5b_no_issue", llc_op, 32'd15);
    tick();
    chk("t5b_bad_op_fall", 32'(bad_op), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd0);
    chk("t5b_count", 32'(log_op.size()), 32'd0);

    // 6: six snoops against one queued CPU request
    clear_log();
    cpu_op   = 4'd0;
    cpu_addr = 32'h700;
    cpu_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int n;
      n = 0;
      snp_valid = 1'b1;
      snp_op    = 4'(3 + (i % 4));
      snp_addr  = 32'h600 + 32'(16 * i);
      while (!snp_ready && n < 50) begin
        tick();
        n++;
        cpu_valid = 1'b0;
      end
      tick();
      cpu_valid = 1'b0;
    end
    snp_valid = 1'b0;
    wait_idle("t6");
`ifdef LLC_SCHED_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      e_op[i] = 4'(3 + (i % 4));
      e_ad[i] = 32'h600 + 32'(16 * i);
    end
    e_op[4] = 4'd0;
    e_ad[4] = 32'h700;
    for (int i = 4; i < 6; i++) begin
      e_op[i+1] = 4'(3 + (i % 4));
      e_ad[i+1] = 32'h600 + 32'(16 * i);
    end
`else
    for (int i = 0; i < 6; i++) begin
      e_op[i] = 4'(3 + (i % 4));
      e_ad[i] = 32'h600 + 32'(16 * i);
    end
    e_op[6] = 4'd0;
    e_ad[6] = 32'h700;
`endif
    chk("t6_count", 32'(log_op.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk_log($sformatf("t6_%0d", i), i, e_op[i], e_ad[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
